// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared types and constants for the key-confirmation handshake
package auth_pkg;

    localparam int W = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GEN       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_CHECK     = 3'd4,
        ST_EVAL      = 3'd5,
        ST_PASS      = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
    localparam logic [1:0] FAIL_MISMATCH = 2'd2;
    localparam logic [1:0] FAIL_ABORT    = 2'd3;

    // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59
    localparam logic [W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q);
        return {q[W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nonce_lfsr.sv
// rtl/nonce_lfsr.sv - 64-bit nonce LFSR that advances only when stepped
module nonce_lfsr
    import auth_pkg::*;
#(
    parameter logic [W-1:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_i,
    output logic [W-1:0] q_o
);

    // An all-zero state would lock the register, so a zero seed becomes 1
    localparam logic [W-1:0] INIT = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_o <= INIT;
        end else if (step_i) begin
            q_o <= lfsr_next(q_o);
        end
    end

endmodule

// File: rtl/auth_handshake_ctrl.sv
// rtl/auth_handshake_ctrl.sv - challenge/response key confirmation with timeout and retry
module auth_handshake_ctrl
    import auth_pkg::*;
#(
    parameter int           TIMEOUT_CYC = 1024,
    parameter int           MAX_TRY     = 3,
    parameter logic [63:0]  LFSR_SEED   = 64'h0000_0000_0000_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_done_i,
    input  logic [W-1:0] k_i,
    input  logic         start_i,
    output logic         chal_valid_o,
    input  logic         chal_ready_i,
    output logic [W-1:0] chal_o,
    input  logic         resp_valid_i,
    input  logic [W-1:0] resp_i,
    output logic         chk_done_o,
    output logic [W-1:0] chk_r1_o,
    output logic [W-1:0] chk_c2_o,
    input  logic         chk_true_i,
    output logic         busy_o,
    output logic         auth_ok_o,
    output logic         auth_fail_o,
    output logic [1:0]   fail_code_o,
    output logic [1:0]   try_cnt_o
);

    localparam int            TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    TRY_MAX = 2'(MAX_TRY);

    state_t         state;
    logic [TW-1:0]  timer;
    logic [W-1:0]   r1;
    logic [W-1:0]   c2;
    logic [W-1:0]   lfsr_q;
    logic           lfsr_step;

    assign lfsr_step = (state == ST_GEN);

    nonce_lfsr #(.SEED(LFSR_SEED)) u_nonce_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step_i (lfsr_step),
        .q_o    (lfsr_q)
    );

    // Challenge is gated so the link sees zero whenever no challenge is offered
    assign chal_o   = chal_valid_o ? (r1 ^ k_i) : '0;
    assign chk_r1_o = r1;
    assign chk_c2_o = c2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            r1           <= '0;
            c2           <= '0;
            chal_valid_o <= 1'b0;
            chk_done_o   <= 1'b0;
            busy_o       <= 1'b0;
            auth_ok_o    <= 1'b0;
            auth_fail_o  <= 1'b0;
            fail_code_o  <= FAIL_NONE;
            try_cnt_o    <= 2'd0;
        end else begin
            chk_done_o <= 1'b0;
            if (busy_o && !key_done_i) begin
                state        <= ST_FAIL;
                chal_valid_o <= 1'b0;
                busy_o       <= 1'b0;
                auth_fail_o  <= 1'b1;
                fail_code_o  <= FAIL_ABORT;
            end else begin
                case (state)
                    ST_IDLE, ST_PASS, ST_FAIL: begin
                        if (start_i && key_done_i) begin
                            state       <= ST_GEN;
                            busy_o      <= 1'b1;
                            try_cnt_o   <= 2'd0;
                            timer       <= '0;
                            auth_ok_o   <= 1'b0;
                            auth_fail_o <= 1'b0;
                            fail_code_o <= FAIL_NONE;
                        end
                    end
                    ST_GEN: begin
                        r1           <= lfsr_next(lfsr_q);
                        try_cnt_o    <= try_cnt_o + 2'd1;
                        chal_valid_o <= 1'b1;
                        state        <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (chal_ready_i) begin
                            chal_valid_o <= 1'b0;
                            timer        <= '0;
                            state        <= ST_WAIT_RESP;
                        end
                    end
                    ST_WAIT_RESP: begin
                        // A response on the final timer cycle still counts
                        if (resp_valid_i) begin
                            c2         <= resp_i;
                            chk_done_o <= 1'b1;
                            state      <= ST_CHECK;
                        end else if (timer == T_LAST) begin
                            if (try_cnt_o < TRY_MAX) begin
                                state <= ST_GEN;
                            end else begin
                                state       <= ST_FAIL;
                                busy_o      <= 1'b0;
                                auth_fail_o <= 1'b1;
                                fail_code_o <= FAIL_TIMEOUT;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        if (chk_true_i) begin
                            state     <= ST_PASS;
                            busy_o    <= 1'b0;
                            auth_ok_o <= 1'b1;
                        end else if (try_cnt_o < TRY_MAX) begin
                            state <= ST_GEN;
                        end else begin
                            state       <= ST_FAIL;
                            busy_o      <= 1'b0;
                            auth_fail_o <= 1'b1;
                            fail_code_o <= FAIL_MISMATCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_auth_handshake_ctrl.sv
// tb/tb_auth_handshake_ctrl.sv - self-checking bench for auth_handshake_ctrl
module tb_auth_handshake_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_done_i = 1'b0;
    logic [63:0] k_i = '0;
    logic        start_i = 1'b0;
    logic        chal_valid_o;
    logic        chal_ready_i = 1'b1;
    logic [63:0] chal_o;
    logic        resp_valid_i = 1'b0;
    logic [63:0] resp_i = '0;
    logic        chk_done_o;
    logic [63:0] chk_r1_o;
    logic [63:0] chk_c2_o;
    logic        chk_true_i = 1'b0;
    logic        busy_o;
    logic        auth_ok_o;
    logic        auth_fail_o;
    logic [1:0]  fail_code_o;
    logic [1:0]  try_cnt_o;

    auth_handshake_ctrl #(.TIMEOUT_CYC(TO), .MAX_TRY(3), .LFSR_SEED(64'h1)) dut (
        .clk(clk), .rst(rst), .key_done_i(key_done_i), .k_i(k_i), .start_i(start_i),
        .chal_valid_o(chal_valid_o), .chal_ready_i(chal_ready_i), .chal_o(chal_o),
        .resp_valid_i(resp_valid_i), .resp_i(resp_i), .chk_done_o(chk_done_o),
        .chk_r1_o(chk_r1_o), .chk_c2_o(chk_c2_o), .chk_true_i(chk_true_i),
        .busy_o(busy_o), .auth_ok_o(auth_ok_o), .auth_fail_o(auth_fail_o),
        .fail_code_o(fail_code_o), .try_cnt_o(try_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] q);
        logic fb;
        fb = q[63] ^ q[62] ^ q[60] ^ q[59];
        return {q[62:0], fb};
    endfunction

    typedef struct packed {
        logic [63:0] r1;
        logic [63:0] c2;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         sb_e;
    logic [63:0] nonce_model = 64'h1;
    int          hs_idx = 0;
    int          hs_cyc[4];
    int          done_cnt = 0;
    int          cyc = 0;
    int          plan[3];
    int          resp_delay = 1;
    logic        resp_armed = 1'b0;
    int          resp_cnt = 0;
    logic [63:0] resp_val = '0;
    logic        chk_pending = 1'b0;

    // Link responder and checker model: observe pre-edge values, push expectations
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (chal_valid_o && chal_ready_i) begin
                nonce_model = lfsr_step(nonce_model);
                check("chal_o", chal_o, nonce_model ^ k_i);
                if (hs_idx < 4) hs_cyc[hs_idx] = cyc;
                if (hs_idx < 3 && plan[hs_idx] != 0) begin
                    resp_val   = (nonce_model ^ k_i) ^ ((plan[hs_idx] == 2) ? 64'h1 : 64'h0);
                    resp_armed = 1'b1;
                    resp_cnt   = resp_delay;
                    sb_q.push_back('{r1: nonce_model, c2: resp_val});
                end
                hs_idx++;
            end
            if (chk_done_o) begin
                done_cnt++;
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("chk_r1_o", chk_r1_o, sb_e.r1);
                    check("chk_c2_o", chk_c2_o, sb_e.c2);
                end
                chk_pending = ((chk_c2_o ^ k_i) == chk_r1_o);
            end
        end
    end

    always @(negedge clk) begin
        resp_valid_i = 1'b0;
        chk_true_i   = chk_pending;
        chk_pending  = 1'b0;
        if (resp_armed) begin
            resp_cnt--;
            if (resp_cnt <= 0) begin
                resp_valid_i = 1'b1;
                resp_i       = resp_val;
                resp_armed   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic new_round(input int p0, input int p1, input int p2, input int dly);
        plan[0] = p0; plan[1] = p1; plan[2] = p2;
        resp_delay = dly;
        hs_idx = 0;
        done_cnt = 0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (!busy_o && (auth_ok_o || auth_fail_o)) break;
        end
        check("round_done_in_budget", 64'(i < budget), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_chal_valid"}, chal_valid_o, 0);
        check({tag, "_chal_o"}, chal_o, 0);
        check({tag, "_chk_done"}, chk_done_o, 0);
        check({tag, "_chk_r1"}, chk_r1_o, 0);
        check({tag, "_chk_c2"}, chk_c2_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ok"}, auth_ok_o, 0);
        check({tag, "_fail"}, auth_fail_o, 0);
        check({tag, "_code"}, fail_code_o, 0);
        check({tag, "_try"}, try_cnt_o, 0);
    endtask

    typedef struct {
        logic [63:0] k;
        int          p0, p1, p2;
        logic        ok, fail;
        logic [1:0]  code, tries;
        int          dones;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t_valid, t_done, t_ok, vcount, bad;
        logic [63:0] held;

        tbl[0] = '{64'hA5A5_A5A5_5A5A_5A5A, 1, 0, 0, 1'b1, 1'b0, 2'd0, 2'd1, 1};
        tbl[1] = '{64'hA5A5_A5A5_5A5A_5A5A, 2, 2, 2, 1'b0, 1'b1, 2'd2, 2'd3, 3};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 0, 1, 0, 1'b1, 1'b0, 2'd0, 2'd2, 1};
        tbl[3] = '{64'hFFFF_0000_FFFF_0000, 0, 0, 0, 1'b0, 1'b1, 2'd1, 2'd3, 0};
        tbl[4] = '{64'hDEAD_BEEF_CAFE_F00D, 2, 1, 0, 1'b1, 1'b0, 2'd0, 2'd2, 2};
        tbl[5] = '{64'h1357_9BDF_2468_ACE0, 2, 2, 0, 1'b0, 1'b1, 2'd1, 2'd3, 2};

        k_i = 64'hA5A5_A5A5_5A5A_5A5A;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;
        key_done_i = 1'b1;
        tick();

        // Latency on an ideal link, first nonce after seed 1 is 2
        new_round(1, 0, 0, 1);
        t_valid = 0; t_done = 0; t_ok = 0;
        start_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) start_i = 1'b0;
            if (chal_valid_o && t_valid == 0) t_valid = i;
            if (chk_done_o && t_done == 0) t_done = i;
            if (auth_ok_o && t_ok == 0) t_ok = i;
        end
        check("lat_send", t_valid, 2);
        check("lat_chk_done", t_done, 4);
        check("lat_auth_ok", t_ok, 6);
        check("lat_try", try_cnt_o, 1);
        check("lat_code", fail_code_o, 0);
        check("lat_first_nonce", chk_r1_o, 64'h2);

        for (int v = 0; v < 6; v++) begin
            k_i = tbl[v].k;
            new_round(tbl[v].p0, tbl[v].p1, tbl[v].p2, 1);
            start_pulse();
            wait_idle(400);
            check($sformatf("v%0d_ok", v), auth_ok_o, tbl[v].ok);
            check($sformatf("v%0d_fail", v), auth_fail_o, tbl[v].fail);
            check($sformatf("v%0d_code", v), fail_code_o, tbl[v].code);
            check($sformatf("v%0d_try", v), try_cnt_o, tbl[v].tries);
            check($sformatf("v%0d_dones", v), done_cnt, tbl[v].dones);
            check($sformatf("v%0d_attempts", v), hs_idx, tbl[v].tries);
            check($sformatf("v%0d_sb_drained", v), sb_q.size(), 0);
            if (tbl[v].p0 == 0)
                check($sformatf("v%0d_retry_gap", v), hs_cyc[1] - hs_cyc[0], TO + 2);
        end

        // Backpressure: ready low for 5 SEND cycles
        k_i = 64'hA5A5_A5A5_5A5A_5A5A;
        new_round(1, 0, 0, 1);
        chal_ready_i = 1'b0;
        vcount = 0; bad = 0; held = '0;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (chal_valid_o) begin
                vcount++;
                if (vcount == 1) held = chal_o;
                else if (chal_o !== held) bad++;
                if (vcount == 6) chal_ready_i = 1'b1;
            end else if (vcount >= 6) begin
                break;
            end
        end
        chal_ready_i = 1'b1;
        check("bp_valid_cycles", vcount, 6);
        check("bp_chal_unstable", bad, 0);
        wait_idle(100);
        check("bp_ok", auth_ok_o, 1);
        check("bp_try", try_cnt_o, 1);

        // Abort: key drops while waiting for the response
        new_round(0, 0, 0, 1);
        start_pulse();
        for (int i = 0; i < 20 && hs_idx == 0; i++) tick();
        tick(); tick();
        check("abort_in_wait", busy_o, 1);
        key_done_i = 1'b0;
        tick();
        check("abort_fail", auth_fail_o, 1);
        check("abort_code", fail_code_o, 3);
        check("abort_busy", busy_o, 0);
        check("abort_chal_valid", chal_valid_o, 0);

        // Start without key is ignored
        start_pulse();
        tick(); tick();
        check("nokey_busy", busy_o, 0);
        check("nokey_fail_kept", auth_fail_o, 1);
        check("nokey_code_kept", fail_code_o, 3);
        key_done_i = 1'b1;
        tick();

        // Response on the exact timeout cycle wins
        new_round(1, 0, 0, TO);
        start_pulse();
        wait_idle(200);
        check("edge_ok", auth_ok_o, 1);
        check("edge_try", try_cnt_o, 1);
        check("edge_attempts", hs_idx, 1);

        // Start while busy is ignored
        new_round(1, 0, 0, 4);
        start_pulse();
        tick(); tick();
        start_pulse();
        wait_idle(200);
        check("busy_start_attempts", hs_idx, 1);
        check("busy_start_try", try_cnt_o, 1);
        check("busy_start_ok", auth_ok_o, 1);

        // Async reset while offering a challenge
        new_round(1, 0, 0, 1);
        chal_ready_i = 1'b0;
        start_pulse();
        for (int i = 0; i < 10 && !chal_valid_o; i++) tick();
        check("rst_in_send", chal_valid_o, 1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        nonce_model = 64'h1;
        sb_q.delete();
        resp_armed = 1'b0;
        chk_pending = 1'b0;
        rst = 1'b1;
        chal_ready_i = 1'b1;
        tick();
        new_round(1, 0, 0, 1);
        start_pulse();
        wait_idle(100);
        check("post_rst_ok", auth_ok_o, 1);
        check("post_rst_nonce", chk_r1_o, 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
